// File: rtl/fifo_bit_serializer.sv
// fifo_bit_serializer
// Pops DATA_WIDTH-bit words from a registered-read sync FIFO and emits them
// one bit per valid/ready transfer. MSB_FIRST selects the bit order.
// Optional build macro: FIFO_SER_PREFETCH_EN adds a one-word prefetch buffer
// so consecutive words stream with no bubble cycles.
//
// state | meaning
// IDLE  | no word in flight, waiting for FIFO not empty
// REQ   | read strobe high for one cycle
// LOAD  | FIFO read data valid, captured into the shift register
// SHIFT | presenting bits to the sink
module fifo_bit_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  bit_o,
  output logic                  bit_valid_o,
  input  logic                  bit_ready_i,
  output logic                  bit_last_o,
  output logic                  busy_o
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, LOAD, SHIFT} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [IW-1:0]         r_idx;
  logic                  r_rd_en;
  logic                  r_valid;

`ifdef FIFO_SER_PREFETCH_EN
  logic [DATA_WIDTH-1:0] r_pf_data;
  logic                  r_pf_valid;
  // Read strobe issued for the prefetch buffer whose data has not landed yet.
  logic                  r_pf_pend;
`endif

  logic                  w_xfer;
  logic                  w_xfer_last;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_xfer      = r_valid && bit_ready_i;
  assign w_xfer_last = w_xfer && (r_idx == LAST_IDX);
  assign w_shifted   = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);

  assign fifo_rd_en_o = r_rd_en;
  assign bit_valid_o  = r_valid;
  assign bit_o        = MSB_FIRST ? r_shreg[DATA_WIDTH-1] : r_shreg[0];
  assign bit_last_o   = r_valid && (r_idx == LAST_IDX);
  assign busy_o       = (r_state != IDLE);

  // Sequencer: FIFO read handshake, word load and bit shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_idx   <= '0;
      r_rd_en <= 1'b0;
      r_valid <= 1'b0;
`ifdef FIFO_SER_PREFETCH_EN
      r_pf_data  <= '0;
      r_pf_valid <= 1'b0;
      r_pf_pend  <= 1'b0;
`endif
    end else begin
      // Read strobe is a single-cycle pulse unless re-armed below.
      r_rd_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!fifo_empty_i) begin
            r_state <= REQ;
            r_rd_en <= 1'b1;
          end
        end
        REQ: begin
          r_state <= LOAD;
        end
        LOAD: begin
          r_shreg <= fifo_rd_data_i;
          r_idx   <= '0;
          r_valid <= 1'b1;
          r_state <= SHIFT;
`ifdef FIFO_SER_PREFETCH_EN
          // A prefetch read that was still in flight at the word boundary
          // lands here and is consumed directly.
          r_pf_pend <= 1'b0;
`endif
        end
        SHIFT: begin
          if (w_xfer_last) begin
`ifdef FIFO_SER_PREFETCH_EN
            if (r_pf_valid) begin
              r_shreg    <= r_pf_data;
              r_idx      <= '0;
              r_pf_valid <= 1'b0;
            end else if (r_pf_pend && !r_rd_en) begin
              // Prefetch data is on the bus this very cycle.
              r_shreg   <= fifo_rd_data_i;
              r_idx     <= '0;
              r_pf_pend <= 1'b0;
            end else if (r_pf_pend) begin
              // Strobe is high now; data arrives next cycle.
              r_valid <= 1'b0;
              r_state <= LOAD;
            end else
`endif
            if (!fifo_empty_i) begin
              r_valid <= 1'b0;
              r_state <= REQ;
              r_rd_en <= 1'b1;
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            if (w_xfer) begin
              r_shreg <= w_shifted;
              r_idx   <= r_idx + 1'b1;
            end
`ifdef FIFO_SER_PREFETCH_EN
            if (r_pf_pend && !r_rd_en) begin
              r_pf_data  <= fifo_rd_data_i;
              r_pf_valid <= 1'b1;
              r_pf_pend  <= 1'b0;
            end else if (!r_pf_valid && !r_pf_pend && !fifo_empty_i) begin
              r_rd_en   <= 1'b1;
              r_pf_pend <= 1'b1;
            end
`endif
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_bit_serializer.sv
// Testbench for fifo_bit_serializer: FIFO model with registered read data,
// sink with optional random backpressure, and a word-level reference check.
module tb_fifo_bit_serializer;

  localparam int DW = 16;
`ifdef FIFO_SER_PREFETCH_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic ready = 1'b1;

  logic          empty0 = 1'b1, rd_en0, bit0, valid0, last0, busy0;
  logic [DW-1:0] rd_data0 = '0;
  logic          empty1 = 1'b1, rd_en1, bit1, valid1, last1, busy1;
  logic [DW-1:0] rd_data1 = '0;

  fifo_bit_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst(rst), .fifo_empty_i(empty0), .fifo_rd_en_o(rd_en0),
    .fifo_rd_data_i(rd_data0), .bit_o(bit0), .bit_valid_o(valid0),
    .bit_ready_i(ready), .bit_last_o(last0), .busy_o(busy0));

  fifo_bit_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst), .fifo_empty_i(empty1), .fifo_rd_en_o(rd_en1),
    .fifo_rd_data_i(rd_data1), .bit_o(bit1), .bit_valid_o(valid1),
    .bit_ready_i(ready), .bit_last_o(last1), .busy_o(busy1));

  logic [DW-1:0] q0[$], q1[$];
  bit out0[$], lastq0[$], out1[$], lastq1[$];
  int xcyc0[$];

  int total = 0, bad = 0, cyc = 0;
  int rd_cnt0 = 0, rd_cnt1 = 0, rd_cyc0 = -1, fall_cyc0 = -1;
  logic prev_stall0 = 1'b0, prev_bit0 = 1'b0, prev_last0 = 1'b0;
  bit rand_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: read strobe sampled at the edge, data registered after it.
  always @(posedge clk) begin
    if (rd_en0) begin
      rd_cnt0++;
      rd_cyc0 = cyc;
      chk("rd_en0_while_empty", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) rd_data0 <= q0.pop_front();
    end
    if (rd_en1) begin
      rd_cnt1++;
      chk("rd_en1_while_empty", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) rd_data1 <= q1.pop_front();
    end
    cyc++;
  end

  // Empty flag update and sink-side monitor, away from the active edge.
  always @(negedge clk) begin
    if (empty0 && q0.size() != 0) fall_cyc0 = cyc;
    empty0 = (q0.size() == 0);
    empty1 = (q1.size() == 0);
    if (rst) begin
      prev_stall0 = 1'b0;
    end else begin
      if (prev_stall0)
        chk("hold_under_backpressure", 32'({valid0, bit0, last0}),
            32'({1'b1, prev_bit0, prev_last0}));
      if (valid0 && ready) begin
        out0.push_back(bit0);
        lastq0.push_back(last0);
        xcyc0.push_back(cyc);
      end
      if (valid1 && ready) begin
        out1.push_back(bit1);
        lastq1.push_back(last1);
      end
      prev_stall0 = valid0 && !ready;
      prev_bit0   = bit0;
      prev_last0  = last0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while ((busy0 || busy1 || q0.size() != 0 || q1.size() != 0) && k < max) begin
      tick(1);
      k++;
    end
    tick(1);
    chk("idle_timeout", 32'(k < max), 32'd1);
  endtask

  task automatic clear_obs();
    out0.delete(); lastq0.delete(); out1.delete(); lastq1.delete(); xcyc0.delete();
    rd_cnt0 = 0; rd_cnt1 = 0;
  endtask

  // Reference: step i of a word carries word[DW-1-i] (MSB first) or word[i].
  task automatic check_stream(input string tag, input logic [DW-1:0] words[$],
                              input bit bits[$], input bit lasts[$], input bit msb);
    logic [DW-1:0] got, lv;
    chk({tag, "_len"}, 32'(bits.size()), 32'(words.size() * DW));
    for (int k = 0; k < words.size(); k++) begin
      got = '0;
      lv  = '0;
      for (int i = 0; i < DW; i++) begin
        int idx = k * DW + i;
        if (idx < bits.size()) begin
          if (msb) got[DW-1-i] = bits[idx];
          else     got[i]      = bits[idx];
          lv[i] = lasts[idx];
        end
      end
      chk({tag, "_word"}, 32'(got), 32'(words[k]));
      chk({tag, "_last"}, 32'(lv), 32'(1) << (DW - 1));
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [DW-1:0] wl[$];
    logic [DW-1:0] w;
    int k, n, rc;

    // Reset state
    tick(3);
    chk("rst_outs_msb", 32'({rd_en0, bit0, valid0, last0, busy0}), 32'd0);
    chk("rst_outs_lsb", 32'({rd_en1, bit1, valid1, last1, busy1}), 32'd0);
    rst = 1'b0;
    tick(2);

    // Single word, both bit orders
    clear_obs();
    q0.push_back(16'hA5C3);
    q1.push_back(16'hA5C3);
    wait_idle(200);
    wl = '{16'hA5C3};
    check_stream("single_msb", wl, out0, lastq0, 1'b1);
    check_stream("single_lsb", wl, out1, lastq1, 1'b0);
    chk("single_rd_cnt_msb", 32'(rd_cnt0), 32'd1);
    chk("single_rd_cnt_lsb", 32'(rd_cnt1), 32'd1);
    chk("single_busy_after", 32'({busy0, busy1}), 32'd0);

    // Three preloaded words, back to back
    clear_obs();
    wl = '{16'h0001, 16'hFFFF, 16'h8000};
    foreach (wl[i]) q0.push_back(wl[i]);
    wait_idle(400);
    check_stream("three", wl, out0, lastq0, 1'b1);
    chk("three_rd_cnt", 32'(rd_cnt0), 32'd3);
    if (xcyc0.size() >= 3 * DW) begin
      for (int j = 0; j < 2; j++)
        chk("three_gap", 32'(xcyc0[(j + 1) * DW] - xcyc0[j * DW + DW - 1] - 1), 32'(EXP_GAP));
    end

    // Random backpressure, 100 words arriving at random times
    clear_obs();
    wl.delete();
    rand_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      w = 16'($urandom);
      wl.push_back(w);
      q0.push_back(w);
      tick($urandom_range(0, 24));
    end
    wait_idle(20000);
    rand_en = 1'b0;
    ready = 1'b1;
    tick(1);
    check_stream("rand", wl, out0, lastq0, 1'b1);
    chk("rand_rd_cnt", 32'(rd_cnt0), 32'd100);

    // Reset in the middle of a word
    clear_obs();
    q0.push_back(16'h1234);
    k = 0;
    while (out0.size() < 7 && k < 200) begin
      tick(1);
      k++;
    end
    chk("midrst_bits_before", 32'(out0.size()), 32'd7);
    #1 rst = 1'b1;
    #1;
    chk("midrst_outs_msb", 32'({rd_en0, bit0, valid0, last0, busy0}), 32'd0);
    chk("midrst_outs_lsb", 32'({rd_en1, bit1, valid1, last1, busy1}), 32'd0);
    tick(2);
    rst = 1'b0;
    n  = out0.size();
    rc = rd_cnt0;
    tick(20);
    chk("midrst_no_rd", 32'(rd_cnt0), 32'(rc));
    chk("midrst_no_bits", 32'(out0.size()), 32'(n));
    chk("midrst_idle", 32'({valid0, busy0}), 32'd0);

    // Empty gap, then a new word: latency from empty falling
    clear_obs();
    q0.push_back(16'h5A3C);
    wait_idle(200);
    tick(5);
    chk("gap_idle_holds", 32'({busy0, rd_en0}), 32'd0);
    clear_obs();
    fall_cyc0 = -1;
    rd_cyc0 = -1;
    q0.push_back(16'h00FF);
    wait_idle(200);
    chk("lat_rd_en", 32'(rd_cyc0 - fall_cyc0), 32'd1);
    if (xcyc0.size() > 0)
      chk("lat_first_bit", 32'(xcyc0[0] - fall_cyc0), 32'd3);
    wl = '{16'h00FF};
    check_stream("w00ff", wl, out0, lastq0, 1'b1);
    chk("w00ff_rd_cnt", 32'(rd_cnt0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
